// File: rtl/major_state_seq_pkg.sv
// Shared encodings for the major-state sequencer: major/minor state codes
// and the opcode patterns the major decision logic looks for.
package major_state_seq_pkg;

  typedef enum logic [2:0] {
    MJ_F = 3'd0,
    MJ_D = 3'd1,
    MJ_E = 3'd2,
    MJ_B = 3'd3,
    MJ_H = 3'd4
  } major_t;

  typedef enum logic [2:0] {
    MN_T0 = 3'd0,
    MN_TW = 3'd1,
    MN_T1 = 3'd2,
    MN_T2 = 3'd3,
    MN_T3 = 3'd4
  } minor_t;

  // IR[0:1] = 11 : IOT or OPR, both finish in the fetch cycle
  localparam logic [1:0]  OP_IOT_OPR = 2'b11;
  // IR[0:3] patterns for JMP direct / JMP indirect
  localparam logic [3:0]  OP_JMP     = 4'b1010;
  localparam logic [3:0]  OP_JMP_I   = 4'b1011;
  // HLT: group-2 OPR (IR[0:3]=1111) with IR[10:11]=10
  localparam logic [3:0]  HLT_HI     = 4'b1111;
  localparam logic [1:0]  HLT_LO     = 2'b10;
  // IOF blocks interrupt entry at the end of its own fetch
  localparam logic [11:0] IR_IOF     = 12'o6002;

endpackage

// File: rtl/major_state_seq_cycle_timer.sv
// Minor-state timer: T0 gate, stretchable TW, then T1..T3. In halt the TW
// slot is the panel decision point and never waits on memory.
module major_state_seq_cycle_timer
  import major_state_seq_pkg::*;
#(
  parameter int WAIT_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] major,
  input  logic       single_step,
  input  logic       cont,
  input  logic       trigger,
  input  logic       mem_busy,
  output logic [2:0] minor,
  output logic       t3,
  output logic       halt_hw
);

  localparam int W_EFF = (WAIT_CYCLES < 1) ? 1 : WAIT_CYCLES;
  localparam int CW = $clog2(W_EFF + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(W_EFF - 1);

  minor_t        minor_q, minor_nxt;
  logic [CW-1:0] cnt;
  logic          in_halt, in_break, major_ok;

  assign in_halt  = (major == MJ_H);
  assign in_break = (major == MJ_B);
  assign major_ok = (major <= MJ_H);

  // Next minor state; an illegal major forces T0 alongside the H recovery
  always_comb begin
    minor_nxt = minor_q;
    if (!major_ok) minor_nxt = MN_T0;
    else begin
      case (minor_q)
        MN_T0: if (in_halt || in_break || !single_step || cont) minor_nxt = MN_TW;
        MN_TW: begin
          if (in_halt) minor_nxt = (trigger && !cont) ? MN_T1 : MN_T0;
          else if (cnt == CNT_LAST && !mem_busy) minor_nxt = MN_T1;
        end
        MN_T1:   minor_nxt = MN_T2;
        MN_T2:   minor_nxt = MN_T3;
        MN_T3:   minor_nxt = MN_T0;
        default: minor_nxt = MN_T0;
      endcase
    end
  end

  // Minor register and TW counter; the counter saturates at the minimum
  // length so mem_busy alone stretches TW beyond it
  always_ff @(posedge clk) begin
    if (!reset) begin
      minor_q <= MN_T0;
      cnt     <= '0;
    end else begin
      minor_q <= minor_nxt;
      if (minor_nxt != MN_TW || in_halt) cnt <= '0;
      else if (minor_q == MN_TW && cnt != CNT_LAST) cnt <= cnt + 1'b1;
    end
  end

  assign minor   = minor_q;
  assign t3      = major_ok && (minor_q == MN_T3);
  assign halt_hw = in_halt && (minor_q == MN_TW);

endmodule

// File: rtl/major_state_seq.sv
// Major-state sequencer: chooses F/D/E/B/H at each T3 (or on panel
// continue in halt) and tracks the interrupt cycle in progress.
module major_state_seq
  import major_state_seq_pkg::*;
#(
  parameter int WAIT_CYCLES = 1,
  parameter bit BREAK_ENA   = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        halt,
  input  logic        single_step,
  input  logic        single_instr,
  input  logic        cont,
  input  logic        trigger,
  input  logic        int_req,
  input  logic        int_ena,
  input  logic        int_inh,
  input  logic        UF,
  input  logic        mem_busy,
  input  logic        brk_req,
  input  logic [0:11] instruction,
  output logic [2:0]  major,
  output logic [2:0]  minor,
  output logic        int_in_prog,
  output logic        brk_ack
);

  major_t major_q, major_nxt, eoi_major;
  logic   iip_nxt, eoi_int, end_instr, no_int, t3, halt_hw;
  logic   op_ends_f, is_hlt, is_iof, is_jmp_i;

  major_state_seq_cycle_timer #(.WAIT_CYCLES(WAIT_CYCLES)) u_cycle_timer (
    .clk         (clk),
    .reset       (reset),
    .major       (major_q),
    .single_step (single_step),
    .cont        (cont),
    .trigger     (trigger),
    .mem_busy    (mem_busy),
    .minor       (minor),
    .t3          (t3),
    .halt_hw     (halt_hw)
  );

  assign op_ends_f = (instruction[0:1] == OP_IOT_OPR) || (instruction[0:3] == OP_JMP);
  assign is_hlt    = (instruction[0:3] == HLT_HI) && (instruction[10:11] == HLT_LO) && !UF;
  assign is_iof    = (instruction == IR_IOF);
  assign is_jmp_i  = (instruction[0:3] == OP_JMP_I);
  // IOF blocks entry at its own fetch; elsewhere an interrupt cycle already
  // under way (E or a break squeezed in after it) blocks re-entry
  assign no_int    = (major_q == MJ_F) ? is_iof : int_in_prog;

  // End-of-instruction choice: halt > break > interrupt > single_instr
  always_comb begin
    eoi_int   = 1'b0;
    eoi_major = MJ_F;
    if (halt) eoi_major = MJ_H;
    else if (brk_req && BREAK_ENA) eoi_major = MJ_B;
    else if (int_req && int_ena && !int_inh && !no_int) begin
      eoi_major = MJ_E;
      eoi_int   = 1'b1;
    end else if (single_instr) eoi_major = MJ_H;
  end

  // Next major state and interrupt-in-progress flag
  always_comb begin
    major_nxt = major_q;
    iip_nxt   = int_in_prog;
    end_instr = 1'b0;
    if (major_q > MJ_H || minor > MN_T3) major_nxt = MJ_H;
    else if (halt_hw && cont) major_nxt = MJ_F;
    else if (t3) begin
      case (major_q)
        MJ_F: begin
          if (op_ends_f) begin
            major_nxt = is_hlt ? MJ_H : eoi_major;
            end_instr = !is_hlt;
          end else major_nxt = instruction[3] ? MJ_D : MJ_E;
        end
        MJ_D: begin
          if (is_jmp_i) begin
            major_nxt = eoi_major;
            end_instr = 1'b1;
          end else major_nxt = MJ_E;
        end
        MJ_E, MJ_B: begin
          major_nxt = eoi_major;
          end_instr = 1'b1;
        end
        default: major_nxt = MJ_H;
      endcase
    end
    if (end_instr && eoi_int) iip_nxt = 1'b1;
    if (major_q == MJ_F && minor == MN_T0) iip_nxt = 1'b0;
  end

  // Major state register
  always_ff @(posedge clk) begin
    if (!reset) begin
      major_q     <= MJ_H;
      int_in_prog <= 1'b0;
    end else begin
      major_q     <= major_nxt;
      int_in_prog <= iip_nxt;
    end
  end

  assign major   = major_q;
  assign brk_ack = BREAK_ENA && (major_q == MJ_B) && t3;

endmodule

// File: tb/tb_major_state_seq.sv
// Bench for major_state_seq: two instances (WAIT_CYCLES=3 with breaks,
// WAIT_CYCLES=0 without) checked every cycle against a behavioural model,
// plus a table of instruction runs and hand-written multi-cycle sequences.
module tb_major_state_seq;

  logic clk = 1'b0;
  logic reset = 1'b0, halt = 1'b0, single_step = 1'b0, single_instr = 1'b0;
  logic cont = 1'b0, trigger = 1'b0, int_req = 1'b0, int_ena = 1'b0;
  logic int_inh = 1'b0, UF = 1'b0, mem_busy = 1'b0, brk_req = 1'b0;
  logic [11:0] ir = 12'o0;
  logic [2:0] major_a, minor_a, major_b, minor_b;
  logic iip_a, ack_a, iip_b, ack_b;

  int nchecks = 0, nerr = 0, ackb_cnt = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  major_state_seq #(.WAIT_CYCLES(3), .BREAK_ENA(1'b1)) dut (
    .clk(clk), .reset(reset), .halt(halt), .single_step(single_step),
    .single_instr(single_instr), .cont(cont), .trigger(trigger),
    .int_req(int_req), .int_ena(int_ena), .int_inh(int_inh), .UF(UF),
    .mem_busy(mem_busy), .brk_req(brk_req), .instruction(ir),
    .major(major_a), .minor(minor_a), .int_in_prog(iip_a), .brk_ack(ack_a));

  major_state_seq #(.WAIT_CYCLES(0), .BREAK_ENA(1'b0)) dut0 (
    .clk(clk), .reset(reset), .halt(halt), .single_step(single_step),
    .single_instr(single_instr), .cont(cont), .trigger(trigger),
    .int_req(int_req), .int_ena(int_ena), .int_inh(int_inh), .UF(UF),
    .mem_busy(mem_busy), .brk_req(brk_req), .instruction(ir),
    .major(major_b), .minor(minor_b), .int_in_prog(iip_b), .brk_ack(ack_b));

  task automatic chk(input string nm, input logic [31:0] act, input int exp);
    nchecks++;
    if (act !== 32'(exp)) begin
      nerr++;
      if (nerr <= 40) $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A cycle is: T0 (maybe gated), a TW run counted in cycles, then a
  // three-cycle tail; the decision at the end of the tail picks the next major.
  typedef struct {
    int mj;    // 0 F, 1 D, 2 E, 3 B, 4 H
    bit t0;    // sitting in T0
    int twn;   // TW cycles spent so far
    int tail;  // 0 = still in TW, 1..3 = T1..T3
    bit iip;
  } mdl_t;

  mdl_t ma = '{4, 1'b1, 0, 0, 1'b0};
  mdl_t mb = '{4, 1'b1, 0, 0, 1'b0};

  function automatic void m_eoi(inout mdl_t n, input bit no_int, input bit bena);
    if (halt) n.mj = 4;
    else if (brk_req && bena) n.mj = 3;
    else if (int_req && int_ena && !int_inh && !no_int) begin n.mj = 2; n.iip = 1'b1; end
    else if (single_instr) n.mj = 4;
    else n.mj = 0;
  endfunction

  function automatic mdl_t mstep(input mdl_t m, input int weff, input bit bena);
    mdl_t n = m;
    int opc = int'(ir >> 9);
    int hi4 = int'(ir >> 8);
    if (!reset) return '{4, 1'b1, 0, 0, 1'b0};
    if (m.t0) begin
      if (m.mj == 0) n.iip = 1'b0;
      if (m.mj == 4 || m.mj == 3 || !single_step || cont) begin n.t0 = 1'b0; n.twn = 0; n.tail = 0; end
    end else if (m.tail == 0) begin
      if (m.mj == 4) begin
        if (cont) begin n.mj = 0; n.t0 = 1'b1; end
        else if (trigger) n.tail = 1;
        else n.t0 = 1'b1;
      end else begin
        n.twn = m.twn + 1;
        if (n.twn >= weff && !mem_busy) n.tail = 1;
      end
    end else if (m.tail < 3) n.tail = m.tail + 1;
    else begin
      n.t0 = 1'b1; n.tail = 0;
      case (m.mj)
        0: begin
          if (opc >= 6 || hi4 == 10) begin
            if (hi4 == 15 && (ir % 4) == 2 && !UF) n.mj = 4;
            else m_eoi(n, ir == 12'o6002, bena);
          end else n.mj = ir[8] ? 1 : 2;
        end
        1: if (hi4 == 11) m_eoi(n, m.iip, bena); else n.mj = 2;
        2, 3: m_eoi(n, m.iip, bena);
        default: n.mj = 4;
      endcase
    end
    return n;
  endfunction

  function automatic int m_minor(input mdl_t m);
    if (m.t0) return 0;
    if (m.tail == 0) return 1;
    return m.tail + 1;
  endfunction

  always @(posedge clk) begin
    if (!reset) chk_en = 1'b1;
    ma = mstep(ma, 3, 1'b1);
    mb = mstep(mb, 1, 1'b0);
  end

  always @(negedge clk) begin
    if (ack_b === 1'b1) ackb_cnt++;
    if (chk_en) begin
      chk("a.major", major_a, ma.mj);
      chk("a.minor", minor_a, m_minor(ma));
      chk("a.int_in_prog", iip_a, ma.iip);
      chk("a.brk_ack", ack_a, (ma.mj == 3 && !ma.t0 && ma.tail == 3) ? 1 : 0);
      chk("b.major", major_b, mb.mj);
      chk("b.minor", minor_b, m_minor(mb));
      chk("b.int_in_prog", iip_b, mb.iip);
      chk("b.brk_ack", ack_b, 0);
    end
  end

  // ---------------- directed helpers ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic quiet();
    halt = 0; single_step = 0; single_instr = 0; cont = 0; trigger = 0;
    int_req = 0; int_ena = 0; int_inh = 0; UF = 0; mem_busy = 0; brk_req = 0;
  endtask

  // Drive dut into F.T0 via halt and a panel continue
  task automatic goto_f();
    int n = 0;
    quiet();
    halt = 1;
    while (!(major_a == 3'd4 && minor_a == 3'd1) && n < 200) begin step(); n++; end
    chk("goto_f.reached_hw", (n < 200) ? 1 : 0, 1);
    halt = 0; cont = 1;
    step();
    cont = 0;
    chk("goto_f.major", major_a, 0);
    chk("goto_f.minor", minor_a, 0);
  endtask

  typedef struct {
    logic [11:0] ir;
    bit uf, hlt, ireq, iena, iinh, si, brk;
    logic [0:3][2:0] seq;  // majors at the next four T0 entries
  } vec_t;

  function automatic vec_t mkv(input logic [11:0] i, input bit uf, hlt, ireq, iena, iinh, si, brk,
                               input logic [2:0] e0, e1, e2, e3);
    vec_t v;
    v.ir = i; v.uf = uf; v.hlt = hlt; v.ireq = ireq; v.iena = iena;
    v.iinh = iinh; v.si = si; v.brk = brk; v.seq = {e0, e1, e2, e3};
    return v;
  endfunction

  vec_t tbl[12];
  logic [11:0] irs[8];

  initial begin
    int n, k, len, twc, acks;
    logic [2:0] prev;
    logic [2:0] got[5];
    logic       giip[5];

    //                 ir        uf hlt irq ien inh si brk   expected majors
    tbl[0]  = mkv(12'o1200, 0, 0, 0, 0, 0, 0, 0, 2, 0, 2, 0);
    tbl[1]  = mkv(12'o7402, 0, 0, 0, 0, 0, 0, 0, 4, 4, 4, 4);
    tbl[2]  = mkv(12'o7402, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[3]  = mkv(12'o7001, 0, 1, 0, 0, 0, 0, 0, 4, 4, 4, 4);
    tbl[4]  = mkv(12'o1400, 0, 0, 1, 1, 0, 0, 0, 1, 2, 2, 0);
    tbl[5]  = mkv(12'o6002, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    tbl[6]  = mkv(12'o7001, 0, 0, 0, 0, 0, 1, 0, 4, 4, 4, 4);
    tbl[7]  = mkv(12'o5200, 0, 0, 0, 0, 0, 0, 1, 3, 3, 3, 3);
    tbl[8]  = mkv(12'o5400, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
    tbl[9]  = mkv(12'o1400, 0, 0, 1, 1, 1, 0, 0, 1, 2, 0, 1);
    tbl[10] = mkv(12'o3000, 0, 0, 1, 1, 0, 1, 0, 2, 2, 4, 4);
    tbl[11] = mkv(12'o1200, 0, 1, 0, 0, 0, 0, 1, 2, 4, 4, 4);
    irs = '{12'o1200, 12'o1400, 12'o3000, 12'o5200, 12'o5400, 12'o6002, 12'o7402, 12'o7001};

    // Reset held for three clocks, then continue out of halt
    reset = 0;
    step(); step(); step();
    chk("reset.major", major_a, 4);
    chk("reset.minor", minor_a, 0);
    chk("reset.int_in_prog", iip_a, 0);
    chk("reset.brk_ack", ack_a, 0);
    reset = 1;
    step();
    chk("reset.hw_minor", minor_a, 1);
    cont = 1;
    step();
    cont = 0;
    chk("reset.cont_major", major_a, 0);
    chk("reset.cont_minor", minor_a, 0);

    // Table of instruction runs from F.T0
    for (int i = 0; i < 12; i++) begin
      goto_f();
      ir = tbl[i].ir; UF = tbl[i].uf; halt = tbl[i].hlt; int_req = tbl[i].ireq;
      int_ena = tbl[i].iena; int_inh = tbl[i].iinh; single_instr = tbl[i].si;
      brk_req = tbl[i].brk;
      for (int j = 0; j < 5; j++) got[j] = 3'bx;
      n = 0; k = 0; prev = minor_a;
      while (k < 4 && n < 300) begin
        step(); n++;
        if (minor_a == 3'd0 && prev != 3'd0) begin got[k] = major_a; k++; end
        prev = minor_a;
      end
      chk($sformatf("tbl%0d.entries", i), k, 4);
      for (int j = 0; j < 4; j++) chk($sformatf("tbl%0d.seq%0d", i, j), got[j], int'(tbl[i].seq[j]));
    end

    // TW stretched by mem_busy on the two cycles after the minimum length
    goto_f();
    ir = 12'o1200; len = 1; twc = 0; n = 0;
    while (n < 50) begin
      step(); n++;
      if (minor_a == 3'd0) break;
      len++;
      if (minor_a == 3'd1) begin twc++; mem_busy = (twc == 3 || twc == 4); end
      else mem_busy = 0;
    end
    mem_busy = 0;
    chk("membusy.f_len", len, 9);
    chk("membusy.tw_len", twc, 5);
    chk("membusy.next_major", major_a, 2);

    // Back-to-back breaks after DCA, then the pending interrupt
    goto_f();
    ir = 12'o3000; int_req = 1; int_ena = 1; brk_req = 1;
    n = 0; k = 0; acks = 0; prev = minor_a;
    while (k < 5 && n < 400) begin
      step(); n++;
      if (ack_a === 1'b1) acks++;
      if (minor_a == 3'd0 && prev != 3'd0) begin
        got[k] = major_a; giip[k] = iip_a; k++;
        if (k == 3) brk_req = 0;
      end
      prev = minor_a;
    end
    chk("brk.entries", k, 5);
    chk("brk.seq0", got[0], 2);
    chk("brk.seq1", got[1], 3);
    chk("brk.seq2", got[2], 3);
    chk("brk.seq3", got[3], 2);
    chk("brk.seq4", got[4], 0);
    chk("brk.iip_in_break", giip[2], 0);
    chk("brk.iip_in_int_e", giip[3], 1);
    chk("brk.ack_pulses", acks, 2);
    step();
    chk("brk.iip_after_ft0", iip_a, 0);
    int_req = 0;

    // Single step stalls at each T0 until a one-clock cont
    goto_f();
    ir = 12'o7001; single_step = 1;
    step(); step(); step();
    chk("sstep.stall1_major", major_a, 0);
    chk("sstep.stall1_minor", minor_a, 0);
    cont = 1; step(); cont = 0;
    chk("sstep.go1_minor", minor_a, 1);
    n = 0;
    while (minor_a != 3'd0 && n < 50) begin step(); n++; end
    step(); step(); step();
    chk("sstep.stall2_major", major_a, 0);
    chk("sstep.stall2_minor", minor_a, 0);
    cont = 1; step(); cont = 0;
    chk("sstep.go2_minor", minor_a, 1);
    single_step = 0;

    // Reset in the middle of a fetch aborts at once
    goto_f();
    ir = 12'o1200;
    step(); step();
    reset = 0; step(); reset = 1;
    chk("midreset.major", major_a, 4);
    chk("midreset.minor", minor_a, 0);

    // Randomised traffic, checked cycle by cycle against the model
    for (int c = 0; c < 4000; c++) begin
      reset        = ($urandom_range(0, 299) != 0);
      halt         = ($urandom_range(0, 24) == 0);
      single_step  = ($urandom_range(0, 3) == 0);
      single_instr = ($urandom_range(0, 9) == 0);
      cont         = ($urandom_range(0, 2) == 0);
      trigger      = ($urandom_range(0, 3) == 0);
      int_req      = 1'($urandom_range(0, 1));
      int_ena      = 1'($urandom_range(0, 1));
      int_inh      = ($urandom_range(0, 3) == 0);
      UF           = 1'($urandom_range(0, 1));
      mem_busy     = ($urandom_range(0, 2) == 0);
      brk_req      = ($urandom_range(0, 5) == 0);
      ir           = ($urandom_range(0, 1) != 0) ? irs[$urandom_range(0, 7)] : 12'($urandom);
      step();
    end
    reset = 1; quiet();
    step();

    chk("b.brk_ack_never", ackb_cnt, 0);
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule

// File: doc/major_state_seq.md
Name: major_state_seq

Overview:
- Parametrised successor to the PDP-8/e major-state sequencer. Generates Fetch/Defer/Execute/Halt cycles and adds Break (data-break/DMA) cycles.
- Adds a configurable, memory-stretchable wait substate and a single-instruction mode.
- Sits between the front panel, interrupt logic and the memory/datapath timing decode.
- Outputs major and minor state separately, so downstream decode is independent of wait length.

Parameters:
- WAIT_CYCLES, 1, minimum cycles spent in TW (0 treated as 1).
- BREAK_ENA, 1, 1 = Break cycles enabled; 0 = brk_req ignored, brk_ack tied 0.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- halt  in  1  panel halt request
- single_step  in  1  gate every T0 on cont
- single_instr  in  1  halt at every instruction end
- cont  in  1  panel continue
- trigger  in  1  panel deposit/examine strobe (halt-time cycle)
- int_req  in  1  interrupt request
- int_ena  in  1  interrupts enabled (ION)
- int_inh  in  1  interrupt inhibit (CIF pending)
- UF  in  1  user-mode flag
- mem_busy  in  1  extend TW while high
- brk_req  in  1  data-break request
- instruction  in  [0:11]  current IR
- major  out  3  F=0, D=1, E=2, B=3, H=4
- minor  out  3  T0=0, TW=1, T1=2, T2=3, T3=4
- int_in_prog  out  1  interrupt (JMS 0) cycle in progress
- brk_ack  out  1  one-cycle pulse: break transfer done

Behaviour:
- Reset (reset=0 at clk edge): major=H, minor=T0, int_in_prog=0, brk_ack=0, wait count=0. Reset mid-cycle aborts immediately.
- Minor sequence (F/D/E/B):
  - T0 -> TW when (~single_step | cont); otherwise stay in T0. B-cycle T0 is never gated.
  - TW lasts max(1, WAIT_CYCLES) cycles, then holds while mem_busy=1.
  - TW -> T1 -> T2 -> T3, one cycle each. Major is decided at T3 and the sequencer re-enters T0.
- Halt minors: T0 -> TW.
  - In TW: trigger & ~cont -> T1; ~cont -> T0; cont -> F.T0.
  - T1 -> T2 -> T3 -> H.T0.
  - mem_busy is ignored in halt.
- F.T3:
  - If opcode is IOT/OPR (IR[0:1]=11) or JMP direct (IR[0:3]=1010): instruction ends here (see end-of-instruction rule).
    - Extra check ahead of break: HLT (IR[0:3]=1111, IR[10:11]=10) with UF=0 -> H.
    - IR=6002 (IOF) suppresses interrupt entry.
  - Else if IR[3]=1 -> D.
  - Else -> E.
- D.T3: JMP I (IR[0:3]=1011) ends the instruction; otherwise -> E.
- E.T3: instruction ends. If int_in_prog=1, interrupt entry is skipped.
- End-of-instruction priority, highest first:
  1. halt -> H
  2. brk_req & BREAK_ENA -> B
  3. int_req & int_ena & ~int_inh -> E, with int_in_prog <= 1
  4. single_instr -> H
  5. otherwise -> F
- B.T3:
  - Pulse brk_ack=1 for exactly this cycle.
  - Then re-evaluate the same priority list: back-to-back breaks while brk_req stays high.
  - A pending interrupt is taken after the final break.
- int_in_prog: set only as above; cleared on the cycle major=F, minor=T0. Break cycles do not change it.
- Simultaneous events: halt beats break beats interrupt beats single_instr. cont has no effect outside T0/HW.
- Illegal major/minor encodings -> H.T0 next cycle.

Decomposition:
- Major and minor codes go in the shared parameters include/package, replacing the flat 5-bit state constants.
- Also in the shared package: opcode match constants (HLT mask, IOF 6002, JMP/JMP I).
- Natural sub-module `cycle_timer`:
  - Owns minor sequencing, the TW counter, mem_busy extension and the T0 single_step gate.
  - Emits a t3 strobe and a halt_hw flag to the major decision logic in major_state_seq.

Test Plan:
- Reset: hold reset=0 3 clks -> major=4, minor=0, int_in_prog=0. Release, cont=1 at HW -> F.T0 next cycle.
- WAIT_CYCLES=3, TAD 1200, mem_busy=1 for 2 clks entering TW -> TW lasts 5 clks; F cycle = 9 clks, then E.
- IR=7402 UF=0 -> H after F.T3. Same with UF=1 -> F.T0. With halt=1 and IR=7001 -> H.
- int_req=int_ena=1, IR=1400 (TAD I) -> F, D, E, E(int_in_prog=1), F. int_in_prog=0 after F.T0. Same with IR=6002 -> no interrupt entry.
- DCA 3000 with brk_req high for 2 break cycles and int_req pending -> E, B, B (two brk_ack pulses), E(int_in_prog=1), F. BREAK_ENA=0 -> no B, brk_ack never 1.
- single_instr=1, IR=7001 -> F then H. single_step=1 -> stalls at each T0 until a 1-clk cont pulse.
